max_pool_2_engine: RTL and testbench

Second 2x2/stride-2 max-pooling stage of the CNN engine. Consumes the conv2 output stream as signed 8-bit pixels in channel-major raster order and computes each pooled pixel using a half-width row buffer. Packs four pooled pixels per 32-bit word and writes them into the max-pool-2 MRAM through its write port (Port A). Signals frame completion to the layer sequencer.

---
 rtl/max_pool_2_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_max_pool_2_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_2_engine.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_2_engine
// Purpose  : Second 2x2 / stride-2 max-pooling stage of the CNN engine.
//            Consumes signed 8-bit conv2 pixels in channel-major raster order.
//            The horizontal max of each pixel pair is kept in a half-width row
//            buffer on even rows and combined with the odd row's pair to form
//            the pooled pixel. Pooled pixels are packed four per 32-bit word
//            and written to the max-pool-2 MRAM through Port A. A partial last
//            word is flushed with a byte-enable mask, then done is pulsed.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            start            - one-cycle frame start (honoured only in IDLE)
//            in_data/in_valid - pixel stream in, in_ready - pixel accepted
//            mram_addr_a/din_a/en_a/we_a - registered MRAM write port
//            busy             - frame in progress, done - end-of-frame pulse
// Config   : define MP2_RELU_EN to clamp each pooled value to max(v, 0)
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_2_engine #(
  parameter int IN_W      = 16,
  parameter int IN_H      = 16,
  parameter int CHANNELS  = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [9:0]  mram_addr_a,
  output logic [31:0] mram_din_a,
  output logic        mram_en_a,
  output logic [3:0]  mram_we_a,
  output logic        busy,
  output logic        done
);

  localparam int COL_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int ROW_W  = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HALF_W = IN_W / 2;
  localparam int BUF_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  // Pooled index range covers the full 1024-word MRAM at four pixels per word.
  localparam int PIDX_W = 12;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [9:0]       BASE     = 10'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [CH_W-1:0]        ch;
  logic [PIDX_W-1:0]      pidx;
  logic [23:0]            pack;     // lanes 0..2; lane 3 goes straight to din
  logic signed [7:0]      h_reg;
  logic signed [7:0]      row_buf [HALF_W];

  logic                   accept;
  logic signed [7:0]      pix;
  logic signed [7:0]      h_max;
  logic signed [7:0]      above;
  logic signed [7:0]      pooled;
  logic signed [7:0]      lane_val;
  logic [BUF_AW-1:0]      buf_idx;
  logic [1:0]             lane;
  logic [9:0]             word_addr;
  logic [3:0]             flush_mask;
  logic                   col_last;
  logic                   row_last;
  logic                   ch_last;

  assign accept = in_valid & in_ready;

  always_comb begin
    pix       = signed'(in_data);
    buf_idx   = BUF_AW'(col >> 1);
    h_max     = (pix > h_reg) ? pix : h_reg;
    above     = row_buf[buf_idx];
    pooled    = (h_max > above) ? h_max : above;
`ifdef MP2_RELU_EN
    lane_val  = pooled[7] ? 8'sd0 : pooled;
`else
    lane_val  = pooled;
`endif
    lane      = pidx[1:0];
    // The word being assembled always belongs to pooled index pidx.
    word_addr = BASE + 10'(pidx >> 2);
    col_last  = (col == COL_LAST);
    row_last  = (row == ROW_LAST);
    ch_last   = (ch == CH_LAST);
    case (lane)
      2'd1:    flush_mask = 4'b0001;
      2'd2:    flush_mask = 4'b0011;
      2'd3:    flush_mask = 4'b0111;
      default: flush_mask = 4'b0000;
    endcase
  end

  // Row buffer holds the even-row horizontal maxima; it needs no reset
  // because every entry is rewritten before the matching odd row reads it.
  always_ff @(posedge clk) begin
    if (!reset && accept && col[0] && !row[0]) begin
      row_buf[buf_idx] <= h_max;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      ch          <= '0;
      pidx        <= '0;
      pack        <= '0;
      h_reg       <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mram_en_a   <= 1'b0;
      mram_we_a   <= 4'h0;
      mram_addr_a <= 10'h0;
      mram_din_a  <= 32'h0;
    end else begin
      // Write strobe and done are single-cycle pulses unless re-armed below.
      mram_en_a <= 1'b0;
      mram_we_a <= 4'h0;
      done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            col      <= '0;
            row      <= '0;
            ch       <= '0;
            pidx     <= '0;
            pack     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (accept) begin
            if (!col[0]) begin
              h_reg <= pix;
            end else if (row[0]) begin
              pidx <= pidx + 1'b1;
              case (lane)
                2'd0: pack[7:0]   <= lane_val;
                2'd1: pack[15:8]  <= lane_val;
                2'd2: pack[23:16] <= lane_val;
                default: begin
                  mram_en_a   <= 1'b1;
                  mram_we_a   <= 4'hF;
                  mram_addr_a <= word_addr;
                  mram_din_a  <= {lane_val, pack};
                  // Cleared so a later partial word carries zero lanes.
                  pack        <= '0;
                end
              endcase
            end

            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row <= '0;
                if (ch_last) begin
                  ch       <= '0;
                  in_ready <= 1'b0;
                  state    <= S_FLUSH;
                end else begin
                  ch <= ch + 1'b1;
                end
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        S_FLUSH: begin
          if (lane != 2'd0) begin
            mram_en_a   <= 1'b1;
            mram_we_a   <= flush_mask;
            mram_addr_a <= word_addr;
            mram_din_a  <= {8'h00, pack};
          end
          state <= S_DONE;
        end

        S_DONE: begin
          // First DONE cycle raises done; the second drops it with busy.
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_2_engine
// Purpose  : Self-checking bench for max_pool_2_engine. A default-size
//            instance and a 2x2x3 instance (BASE_ADDR=5) are exercised; the
//            expected MRAM write stream is built from the pooling rules by a
//            plain-arithmetic model over the whole input frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_2_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mram_en_a, busy, done;
  logic [9:0]  mram_addr_a;
  logic [31:0] mram_din_a;
  logic [3:0]  mram_we_a;

  // small instance
  logic        s_start, s_in_valid;
  logic [7:0]  s_in_data;
  logic        s_in_ready, s_mram_en_a, s_busy, s_done;
  logic [9:0]  s_mram_addr_a;
  logic [31:0] s_mram_din_a;
  logic [3:0]  s_mram_we_a;

  max_pool_2_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mram_addr_a(mram_addr_a), .mram_din_a(mram_din_a),
    .mram_en_a(mram_en_a), .mram_we_a(mram_we_a),
    .busy(busy), .done(done)
  );

  max_pool_2_engine #(.IN_W(2), .IN_H(2), .CHANNELS(3), .BASE_ADDR(5)) dut_s (
    .clk(clk), .reset(reset), .start(s_start),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .mram_addr_a(s_mram_addr_a), .mram_din_a(s_mram_din_a),
    .mram_en_a(s_mram_en_a), .mram_we_a(s_mram_we_a),
    .busy(s_busy), .done(s_done)
  );

  localparam int N_PIX = 16 * 16 * 8;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- write monitor ----------------
  int          cyc = 0;
  bit          mon_sel = 1'b0;   // 0: default instance, 1: small instance
  logic [9:0]  got_addr [$];
  logic [3:0]  got_we   [$];
  logic [31:0] got_din  [$];
  int          last_wr_cyc, done_cyc, done_cnt;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!mon_sel) begin
      if (mram_en_a) begin
        got_addr.push_back(mram_addr_a); got_we.push_back(mram_we_a);
        got_din.push_back(mram_din_a);   last_wr_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end else begin
      if (s_mram_en_a) begin
        got_addr.push_back(s_mram_addr_a); got_we.push_back(s_mram_we_a);
        got_din.push_back(s_mram_din_a);   last_wr_cyc = cyc;
      end
      if (s_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // ---------------- reference model ----------------
  logic signed [7:0] px [N_PIX];
  logic [9:0]  exp_addr [$];
  logic [3:0]  exp_we   [$];
  logic [31:0] exp_din  [$];

  task automatic build_exp(input int w, input int h, input int c, input int base);
    int p;
    int m, v;
    logic [31:0] word;
    exp_addr.delete(); exp_we.delete(); exp_din.delete();
    p = 0; word = 0;
    for (int ch = 0; ch < c; ch++)
      for (int py = 0; py < h / 2; py++)
        for (int qx = 0; qx < w / 2; qx++) begin
          m = -1000;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = int'(px[ch*w*h + (2*py+dy)*w + 2*qx + dx]);
              if (v > m) m = v;
            end
`ifdef MP2_RELU_EN
          if (m < 0) m = 0;
`endif
          word[8*(p%4) +: 8] = m[7:0];
          p++;
          if (p % 4 == 0) begin
            exp_addr.push_back(10'(base + p/4 - 1)); exp_we.push_back(4'hF);
            exp_din.push_back(word); word = 0;
          end
        end
    if (p % 4 != 0) begin
      exp_addr.push_back(10'(base + p/4)); exp_we.push_back(4'((1 << (p%4)) - 1));
      exp_din.push_back(word);
    end
  endtask

  task automatic clear_mon();
    got_addr.delete(); got_we.delete(); got_din.delete();
    done_cnt = 0; last_wr_cyc = -100; done_cyc = -1;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwords"}, got_din.size(), exp_din.size());
    n = (got_din.size() < exp_din.size()) ? got_din.size() : exp_din.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_we[%0d]",   tag, i), got_we[i],   exp_we[i]);
      check($sformatf("%s_din[%0d]",  tag, i), got_din[i],  exp_din[i]);
    end
  endtask

  // Streams px[] into the default instance. abort_at >= 0 stops after that
  // many accepted pixels and leaves the frame unfinished.
  task automatic run_main(input string tag, input bit gaps, input bit pulse_mid,
                          input int abort_at);
    int idx, guard;
    bit acc;
    clear_mon();
    build_exp(16, 16, 8, 0);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_ready_rise"}, in_ready, 1'b1);
    idx = 0; guard = 0;
    while (idx < N_PIX && guard < 20000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      in_valid = gaps ? 1'($urandom_range(1)) : 1'b1;
      in_data  = px[idx];
      start    = pulse_mid && (idx >= 700) && (idx < 703);
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (abort_at < 0) begin
      check({tag, "_pixels_in_budget"}, idx, N_PIX);
      guard = 0;
      while (done_cnt == 0 && guard < 50) begin @(posedge clk); guard++; end
      check({tag, "_done_seen"}, done_cnt, 1);
      compare_writes(tag);
      // P is a multiple of 4: no flush write, so done lags the last write by 2
      check({tag, "_done_lag"}, done_cyc - last_wr_cyc, 2);
      repeat (2) @(posedge clk); #1;
      check({tag, "_busy_fall"}, busy, 1'b0);
      check({tag, "_done_pulse"}, done_cnt, 1);
    end
  endtask

  int n0, guard;
  bit acc;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h0;
    clear_mon();
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_en", mram_en_a, 1'b0);
    check("rst_we", mram_we_a, 4'h0);
    check("rst_addr", mram_addr_a, 10'h0);
    check("rst_din", mram_din_a, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ramp pattern, gap-free
    for (int i = 0; i < N_PIX; i++) px[i] = 8'(i % 128);
    run_main("ramp", 1'b0, 1'b0, -1);

    // ramp pattern again with random in_valid gaps
    run_main("ramp_gap", 1'b1, 1'b0, -1);

    // uniform negative frame
    for (int i = 0; i < N_PIX; i++) px[i] = -8'sd3;
    run_main("neg3", 1'b0, 1'b0, -1);

    // random data, gaps, start pulsed mid-frame
    for (int i = 0; i < N_PIX; i++) px[i] = 8'($urandom);
    run_main("rnd_start", 1'b1, 1'b1, -1);

    // reset after 100 accepted pixels
    for (int i = 0; i < N_PIX; i++) px[i] = 8'($urandom);
    run_main("abort", 1'b0, 1'b0, 100);
    @(negedge clk); n0 = got_din.size();
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    repeat (30) @(posedge clk); #1;
    check("abort_no_writes", got_din.size(), n0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", in_ready, 1'b0);
    check("abort_no_done", done_cnt, 0);
    for (int i = 0; i < N_PIX; i++) px[i] = 8'($urandom);
    run_main("after_abort", 1'b1, 1'b0, -1);

    // small instance: partial flush word
    mon_sel = 1'b1;
    clear_mon();
    px[0] = 8'sd1;  px[1] = 8'sd7;  px[2]  = 8'sd4;  px[3]  = 8'sd2;
    px[4] = -8'sd8; px[5] = -8'sd9; px[6]  = -8'sd1; px[7]  = -8'sd6;
    px[8] = 8'sd0;  px[9] = 8'sd3;  px[10] = 8'sd3;  px[11] = 8'sd0;
    build_exp(2, 2, 3, 5);
    s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
    n0 = 0; guard = 0;
    while (n0 < 12 && guard < 200) begin
      s_in_valid = 1'b1; s_in_data = px[n0];
      acc = s_in_valid && s_in_ready;
      @(posedge clk); #1;
      if (acc) n0++;
      guard++;
    end
    s_in_valid = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 50) begin @(posedge clk); guard++; end
    check("small_done_seen", done_cnt, 1);
    compare_writes("small");
    check("small_done_lag", done_cyc - last_wr_cyc, 1);
    repeat (2) @(posedge clk); #1;
    check("small_busy_fall", s_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
